// File: rtl/pmem_pkg.sv
// Shared PMEM parameters and requester index type, used by the corelet, the SFU and the arbiter.
package pmem_pkg;
  localparam int PMEM_AW       = 9;
  localparam int PMEM_DW       = 128;
  localparam int N_REQ_DEFAULT = 3;

  typedef logic [$clog2(N_REQ_DEFAULT)-1:0] req_idx_t;
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr_i, wrapping; ptr_i=0 gives fixed lowest-index priority.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  always_comb begin
    int j;
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    // Walk from farthest to nearest so the candidate closest to ptr_i is written last.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        onehot_o    = '0;
        onehot_o[j] = 1'b1;
        idx_o       = IW'(j);
        valid_o     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pmem_arbiter.sv
// Single-port PSUM memory arbiter: lock > urgent/starved > round-robin, with one-cycle read return routing.
module pmem_arbiter
  import pmem_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEFAULT,
  parameter int AW       = PMEM_AW,
  parameter int DW       = PMEM_DW,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    we,
  input  logic [N_REQ-1:0]    urgent,
  input  logic [N_REQ-1:0]    lock,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  input  logic [DW-1:0]       OP_q,
  output logic [DW-1:0]       OP_d,
  output logic [AW-1:0]       OP_addr,
  output logic                OP_cen,
  output logic                OP_wen
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [IW-1:0]            ptr_q, ptr_d;
  logic [IW-1:0]            owner_q, owner_d;
  logic                     owner_vld_q, owner_vld_d;
  logic [N_REQ-1:0][CW-1:0] wait_q, wait_d;
  logic                     tag_vld_q, tag_vld_d;
  logic [IW-1:0]            tag_idx_q, tag_idx_d;

  logic [N_REQ-1:0] starved, eff_urg, urg_oh, rr_oh;
  logic [IW-1:0]    urg_idx, rr_idx, win_idx;
  logic             urg_any, rr_any, win_any, lock_act;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) starved[i] = (wait_q[i] == CW'(MAX_WAIT));
  end

  assign eff_urg  = (urgent | starved) & req;
  // The lock lapses in the very cycle req or lock drops, so that cycle arbitrates normally.
  assign lock_act = owner_vld_q & req[owner_q] & lock[owner_q];

  rr_pick #(.N(N_REQ), .IW(IW)) u_urg_pick (
    .req_i(eff_urg), .ptr_i('0), .onehot_o(urg_oh), .idx_o(urg_idx), .valid_o(urg_any)
  );

  rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
    .req_i(req), .ptr_i(ptr_q), .onehot_o(rr_oh), .idx_o(rr_idx), .valid_o(rr_any)
  );

  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    if (reset) begin
      if (lock_act) begin
        win_any = 1'b1;
        win_idx = owner_q;
      end else if (urg_any) begin
        win_any = 1'b1;
        win_idx = urg_idx;
      end else if (rr_any) begin
        win_any = 1'b1;
        win_idx = rr_idx;
      end
    end
  end

  always_comb begin
    gnt     = '0;
    OP_cen  = 1'b1;
    OP_wen  = 1'b1;
    OP_addr = '0;
    OP_d    = '0;
    if (win_any) begin
      gnt[win_idx] = 1'b1;
      OP_cen       = 1'b0;
      OP_wen       = ~we[win_idx];
      OP_addr      = addr[win_idx*AW +: AW];
      OP_d         = wdata[win_idx*DW +: DW];
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    owner_vld_d = 1'b0;
    tag_vld_d   = 1'b0;
    tag_idx_d   = tag_idx_q;
    wait_d      = wait_q;
    if (win_any) begin
      ptr_d       = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      owner_d     = win_idx;
      owner_vld_d = lock[win_idx];
      tag_vld_d   = ~we[win_idx];
      tag_idx_d   = win_idx;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && !gnt[i]) begin
        if (wait_q[i] != CW'(MAX_WAIT)) wait_d[i] = wait_q[i] + 1'b1;
      end else begin
        wait_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      wait_q      <= '0;
      tag_vld_q   <= 1'b0;
      tag_idx_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      wait_q      <= wait_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
    end
  end

  // OP_q is the SRAM's own output register, so the cycle after a read grant it already holds the data.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (reset && tag_vld_q) begin
      rvalid[tag_idx_q] = 1'b1;
      rdata             = OP_q;
    end
  end
endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_pmem_arbiter;
  localparam int N  = 3;
  localparam int AW = 9;
  localparam int DW = 128;
  localparam int MW = 15;

  // Clock/reset block.
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0, we = '0, urgent = '0, lock = '0;
  logic [AW-1:0]   a_arr[N];
  logic [DW-1:0]   d_arr[N];
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, OP_d, sram_q;
  logic [AW-1:0]   OP_addr;
  logic            OP_cen, OP_wen;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW]  = a_arr[i];
      wdata[i*DW +: DW] = d_arr[i];
    end
  end

  pmem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .urgent(urgent), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .OP_q(sram_q), .OP_d(OP_d), .OP_addr(OP_addr), .OP_cen(OP_cen), .OP_wen(OP_wen)
  );

  // Environment SRAM: registered read output, write at the enable edge.
  logic [DW-1:0] sram_mem[1<<AW];
  always @(posedge clk) begin
    if (!OP_cen) begin
      if (!OP_wen) sram_mem[OP_addr] <= OP_d;
      else         sram_q <= sram_mem[OP_addr];
    end
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Scoreboard / behavioural model: state as it will be after the coming rising edge.
  int            m_ptr = 0;
  int            m_owner = -1;
  int            m_wait[N];
  bit            m_rd = 1'b0;
  int            m_rd_idx = 0;
  logic [DW-1:0] m_mem[1<<AW];
  logic [DW-1:0] exp_q[$];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_wait[i] = 0;
      a_arr[i]  = '0;
      d_arr[i]  = '0;
    end
    for (int a = 0; a < (1 << AW); a++) begin
      sram_mem[a] = {4{32'(a) * 32'h9E3779B1}};
      m_mem[a]    = {4{32'(a) * 32'h9E3779B1}};
    end
  end

  always @(negedge clk) begin
    int w;
    logic [N-1:0]  eg, erv;
    logic [DW-1:0] erd;
    w = -1;
    if (reset) begin
      if (m_owner >= 0 && req[m_owner] && lock[m_owner]) w = m_owner;
      for (int i = 0; i < N; i++)
        if (w < 0 && req[i] && (urgent[i] || m_wait[i] == MW)) w = i;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    end
    eg  = (w >= 0) ? N'(1 << w) : '0;
    erv = '0;
    erd = '0;
    if (m_rd) begin
      erd = exp_q.pop_front();
      if (reset) erv = N'(1 << m_rd_idx);
      else       erd = '0;
    end
    chk("gnt", DW'(gnt), DW'(eg));
    chk("op_cen", DW'(OP_cen), DW'(w < 0));
    chk("op_wen", DW'(OP_wen), DW'((w < 0) ? 1'b1 : !we[w]));
    chk("op_addr", DW'(OP_addr), (w < 0) ? '0 : DW'(a_arr[w]));
    chk("op_d", OP_d, (w < 0) ? '0 : d_arr[w]);
    chk("rvalid", DW'(rvalid), DW'(erv));
    chk("rdata", rdata, erd);

    if (!reset) begin
      m_ptr   = 0;
      m_owner = -1;
      m_rd    = 1'b0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
    end else begin
      m_rd = 1'b0;
      if (w >= 0) begin
        m_ptr   = (w + 1) % N;
        m_owner = lock[w] ? w : -1;
        if (we[w]) m_mem[a_arr[w]] = d_arr[w];
        else begin
          m_rd     = 1'b1;
          m_rd_idx = w;
          exp_q.push_back(m_mem[a_arr[w]]);
        end
      end else begin
        m_owner = -1;
      end
      for (int i = 0; i < N; i++)
        m_wait[i] = (req[i] && i != w) ? ((m_wait[i] < MW) ? m_wait[i] + 1 : MW) : 0;
    end
  end

  // Driver task: change inputs just after a rising edge, return just after the following falling edge.
  task automatic drive(input logic rst, input logic [N-1:0] r, input logic [N-1:0] w,
                       input logic [N-1:0] u, input logic [N-1:0] l);
    @(posedge clk);
    #1;
    reset = rst; req = r; we = w; urgent = u; lock = l;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] exp_g[6];
    logic [N-1:0] g;
    bit keep;
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // Reset holds everything idle even with requests present.
    drive(1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
    drive(1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
    chk("rst_gnt", DW'(gnt), '0);
    chk("rst_cen", DW'(OP_cen), DW'(1'b1));
    chk("rst_rvalid", DW'(rvalid), '0);

    // Round-robin reads.
    for (int i = 0; i < N; i++) a_arr[i] = AW'(20 + i);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 3'b111, 3'b000, 3'b000, 3'b000);
      chk("rr_gnt", DW'(gnt), DW'(exp_g[k]));
      if (k > 0) chk("rr_rvalid", DW'(rvalid), DW'(exp_g[k-1]));
    end
    drive(1'b1, 3'b000, 3'b000, 3'b000, 3'b000);
    chk("rr_rvalid_last", DW'(rvalid), DW'(3'b100));
    chk("rr_rdata_last", rdata, {4{32'd22 * 32'h9E3779B1}});

    // Urgent override with ptr=1.
    drive(1'b1, 3'b001, 3'b000, 3'b000, 3'b000);
    drive(1'b1, 3'b011, 3'b000, 3'b001, 3'b000);
    chk("urg_gnt", DW'(gnt), DW'(3'b001));
    drive(1'b1, 3'b011, 3'b000, 3'b000, 3'b000);
    chk("urg_ptr_after", DW'(gnt), DW'(3'b010));
    drive(1'b1, 3'b000, 3'b000, 3'b000, 3'b000);

    // Lock burst beats a standing urgent request.
    drive(1'b1, 3'b100, 3'b000, 3'b000, 3'b100);
    chk("lock_gnt0", DW'(gnt), DW'(3'b100));
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 3'b111, 3'b000, 3'b001, 3'b100);
      chk("lock_gnt", DW'(gnt), DW'(3'b100));
    end
    drive(1'b1, 3'b011, 3'b000, 3'b001, 3'b000);
    chk("lock_release", DW'(gnt), DW'(3'b001));
    drive(1'b1, 3'b010, 3'b000, 3'b000, 3'b000);
    chk("lock_after", DW'(gnt), DW'(3'b010));

    // Watchdog must not break a lock; dropping the lock hands over the same cycle.
    drive(1'b1, 3'b010, 3'b000, 3'b000, 3'b010);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 3'b110, 3'b000, 3'b000, 3'b010);
      chk("wd_locked", DW'(gnt), DW'(3'b010));
    end
    drive(1'b1, 3'b110, 3'b000, 3'b000, 3'b000);
    chk("wd_handover", DW'(gnt), DW'(3'b100));
    drive(1'b1, 3'b010, 3'b000, 3'b000, 3'b000);
    drive(1'b1, 3'b000, 3'b000, 3'b000, 3'b000);

    // Write then read back through a different requester.
    a_arr[0] = 9'd300;
    d_arr[0] = {16{8'hA5}};
    drive(1'b1, 3'b001, 3'b001, 3'b000, 3'b000);
    chk("wr_gnt", DW'(gnt), DW'(3'b001));
    chk("wr_wen", DW'(OP_wen), DW'(1'b0));
    a_arr[2] = 9'd300;
    drive(1'b1, 3'b100, 3'b000, 3'b000, 3'b000);
    chk("rd_gnt", DW'(gnt), DW'(3'b100));
    drive(1'b1, 3'b000, 3'b000, 3'b000, 3'b000);
    chk("rd_rvalid", DW'(rvalid), DW'(3'b100));
    chk("rd_rdata", rdata, {16{8'hA5}});

    // Reset arriving the cycle after a read grant.
    drive(1'b1, 3'b010, 3'b000, 3'b000, 3'b000);
    drive(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
    chk("rstrd_rvalid", DW'(rvalid), '0);
    chk("rstrd_cen", DW'(OP_cen), DW'(1'b1));
    drive(1'b1, 3'b111, 3'b000, 3'b000, 3'b000);
    chk("rstrd_ptr0", DW'(gnt), DW'(3'b001));
    chk("rstrd_no_rvalid", DW'(rvalid), '0);
    drive(1'b1, 3'b000, 3'b000, 3'b000, 3'b000);

    // Random traffic honouring the hold-until-granted contract.
    for (int n = 0; n < 2000; n++) begin
      g = gnt;
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < N; i++) begin
        keep = req[i] && !g[i];
        if (!keep) begin
          req[i]   = ($urandom_range(0, 99) < 60);
          we[i]    = $urandom_range(0, 1);
          a_arr[i] = AW'($urandom_range(0, 15));
          d_arr[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        urgent[i] = ($urandom_range(0, 99) < 8);
        lock[i]   = ($urandom_range(0, 99) < 15);
      end
      @(negedge clk);
      #1;
    end

    drive(1'b1, 3'b000, 3'b000, 3'b000, 3'b000);
    drive(1'b1, 3'b000, 3'b000, 3'b000, 3'b000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
